// File: rtl/word_slice_serializer_pkg.sv
// Shared types and defaults for the word slice serializer: FSM state encoding
// and the default word/slice geometry.
package word_slice_serializer_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SLICE_DEF = 8;
  localparam int IDX_W     = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/word_slice_serializer_slice_and_8.sv
// Slice-wide AND reduction from the reduction library; flags a slice whose
// bits are all ones.
module slice_and_8 #(
  parameter int N = 8
) (
  input  logic [N-1:0] data_i,
  output logic         all_ones_o
);

  assign all_ones_o = &data_i;

endmodule

// File: rtl/word_slice_serializer.sv
// Serializes one WIDTH-bit word into NSLICE slices, LSB slice first, with
// per-slice and whole-word all-ones flags for the narrow status bus.
module word_slice_serializer
  import word_slice_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SLICE-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_all_ones,
  output logic             word_all_ones
);

  localparam int               NSLICE   = WIDTH / SLICE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e                          state_q, state_d;
  logic [WIDTH-1:0]                word_q, word_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            acc_q, acc_d;

  logic                            out_valid_q;
  logic [SLICE-1:0]                out_data_q;
  logic [IDX_W-1:0]                out_idx_q;
  logic                            out_last_q;
  logic                            out_all_ones_q;

  logic [NSLICE-1:0][SLICE-1:0]    word_slices_d;
  logic [SLICE-1:0]                slice_d;
  logic                            slice_all_ones_d;
  logic                            send_d;
  logic                            in_hs;
  logic                            out_hs;

  assign out_hs   = out_valid_q & out_ready;
  assign in_ready = (state_q == IDLE) | (out_hs & out_last_q);
  assign in_hs    = in_valid & in_ready;

  // Next-state logic: load, advance slice index, or return to idle.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (in_hs) begin
          word_d  = in_data;
          idx_d   = IDX_ZERO;
          acc_d   = 1'b1;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (out_hs && out_last_q) begin
          // Last slice leaving: chain straight into a waiting word, no bubble.
          idx_d = IDX_ZERO;
          acc_d = 1'b1;
          if (in_valid) begin
            word_d  = in_data;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else if (out_hs) begin
          acc_d = acc_q & out_all_ones_q;
          idx_d = idx_q + IDX_ONE;
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = IDX_ZERO;
        acc_d   = 1'b1;
      end
    endcase
  end

  assign send_d        = (state_d == SEND);
  assign word_slices_d = word_d;

  // Slice that the output registers will present next cycle; zero when idle.
  always_comb begin
    slice_d = '0;
    if (send_d) begin
      slice_d = word_slices_d[idx_d];
    end else begin
      slice_d = '0;
    end
  end

  slice_and_8 #(
    .N (SLICE)
  ) u_slice_and (
    .data_i     (slice_d),
    .all_ones_o (slice_all_ones_d)
  );

  // Core state: FSM, held word, slice index and running all-ones accumulator.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= IDX_ZERO;
      acc_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  // Output registers, computed from next state so they track the core state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_idx_q      <= IDX_ZERO;
      out_last_q     <= 1'b0;
      out_all_ones_q <= 1'b0;
    end else begin
      out_valid_q    <= send_d;
      out_data_q     <= slice_d;
      out_idx_q      <= idx_d;
      out_last_q     <= send_d & (idx_d == LAST_IDX);
      out_all_ones_q <= send_d & slice_all_ones_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_idx       = out_idx_q;
  assign out_last      = out_last_q;
  assign out_all_ones  = out_all_ones_q;
  assign word_all_ones = out_last_q & acc_q & out_all_ones_q;

endmodule

// File: tb/tb_word_slice_serializer.sv
// Self-checking bench for word_slice_serializer: directed scenarios plus a
// randomized stream checked against a word-level reference model.
module tb_word_slice_serializer;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        out_all_ones;
  logic        word_all_ones;

  int n_checks = 0;
  int n_pass   = 0;

  word_slice_serializer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_idx       (out_idx),
    .out_last      (out_last),
    .out_all_ones  (out_all_ones),
    .word_all_ones (word_all_ones)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
    logic [31:0] sh;
    sh = (w >> (8 * i)) & 32'h0000_00FF;
    return sh[7:0];
  endfunction

  // Expected {valid,data,idx,last,all_ones,word_all_ones} for slice i of w.
  function automatic logic [13:0] exp_slice(input logic [31:0] w, input int i);
    logic [7:0] b;
    logic [1:0] ix;
    b  = exp_byte(w, i);
    ix = i[1:0];
    return {1'b1, b, ix, (i == 3), (b == 8'hFF), (i == 3) && (w == 32'hFFFF_FFFF)};
  endfunction

  function automatic logic [13:0] act_slice();
    return {out_valid, out_data, out_idx, out_last, out_all_ones, word_all_ones};
  endfunction

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    #1;
    n_checks++;
    if ({act_slice(), in_ready} !== {14'h0, 1'b1})
      $display("FAIL reset_state: got %h expected %h", {act_slice(), in_ready}, {14'h0, 1'b1});
    else n_pass++;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01)
        $display("FAIL reset_release_idle: got %b expected 01", {out_valid, in_ready});
      else n_pass++;
    end
  endtask

  task automatic test_single(input logic [31:0] w, input string tag);
    @(negedge clock);
    in_valid  = 1'b1;
    in_data   = w;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1)
      $display("FAIL %s_accept: in_ready got %b expected 1", tag, in_ready);
    else n_pass++;
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = $urandom;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({act_slice(), in_ready} !== {exp_slice(w, i), (i == 3)})
        $display("FAIL %s_slice%0d: got %h expected %h", tag, i,
                 {act_slice(), in_ready}, {exp_slice(w, i), (i == 3)});
      else n_pass++;
      @(negedge clock);
    end
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL %s_idle_after: got %b expected 01", tag, {out_valid, in_ready});
    else n_pass++;
  endtask

  task automatic test_back_to_back(input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] w;
    @(negedge clock);
    in_valid  = 1'b1;
    in_data   = w0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k == 0) in_data = w1;
      if (k == 4) in_valid = 1'b0;
      #1;
      w = (k < 4) ? w0 : w1;
      n_checks++;
      if ({act_slice(), in_ready} !== {exp_slice(w, k % 4), (k % 4 == 3)})
        $display("FAIL b2b_slot%0d: got %h expected %h", k,
                 {act_slice(), in_ready}, {exp_slice(w, k % 4), (k % 4 == 3)});
      else n_pass++;
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL b2b_idle_after: out_valid got %b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure(input logic [31:0] w);
    @(negedge clock);
    in_valid  = 1'b1;
    in_data   = w;
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (act_slice() !== exp_slice(w, 0))
      $display("FAIL bp_slice0: got %h expected %h", act_slice(), exp_slice(w, 0));
    else n_pass++;
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = ~w;
      #1;
      n_checks++;
      if ({act_slice(), in_ready} !== {exp_slice(w, 1), 1'b0})
        $display("FAIL bp_stall%0d: got %h expected %h", s,
                 {act_slice(), in_ready}, {exp_slice(w, 1), 1'b0});
      else n_pass++;
    end
    for (int i = 1; i < 4; i++) begin
      @(negedge clock);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      #1;
      n_checks++;
      if ({act_slice(), in_ready} !== {exp_slice(w, i), (i == 3)})
        $display("FAIL bp_resume%0d: got %h expected %h", i,
                 {act_slice(), in_ready}, {exp_slice(w, i), (i == 3)});
      else n_pass++;
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL bp_idle_after: out_valid got %b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    @(negedge clock);
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if (act_slice() !== exp_slice(32'hFFFF_FFFF, 2))
      $display("FAIL midrst_before: got %h expected %h", act_slice(), exp_slice(32'hFFFF_FFFF, 2));
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({act_slice(), in_ready} !== {14'h0, 1'b1})
      $display("FAIL midrst_async: got %h expected %h", {act_slice(), in_ready}, {14'h0, 1'b1});
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      #1;
      n_checks++;
      if (out_valid !== 1'b0)
        $display("FAIL midrst_no_partial%0d: out_valid got %b expected 0", c, out_valid);
      else n_pass++;
    end
    test_single(32'h0000_0000, "midrst_new");
  endtask

  task automatic test_random_stream();
    logic [31:0] words [24];
    int          wi;
    int          n_out;
    logic        pres;
    logic [31:0] w;
    for (int j = 0; j < 24; j++) begin
      case ($urandom_range(0, 3))
        0:       words[j] = 32'hFFFF_FFFF;
        1:       words[j] = {8'hFF, 8'hFF, $urandom_range(0, 255)%256 == 0 ? 8'h00 : 8'hFF, 8'h7F};
        default: words[j] = $urandom;
      endcase
    end
    wi    = 0;
    n_out = 0;
    pres  = 1'b0;
    for (int cyc = 0; cyc < 3000 && n_out < 96; cyc++) begin
      @(negedge clock);
      if (!pres && wi < 24 && $urandom_range(0, 3) != 0) pres = 1'b1;
      in_valid  = pres;
      in_data   = pres ? words[wi] : $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid) begin
        w = words[n_out / 4];
        n_checks++;
        if (act_slice() !== exp_slice(w, n_out % 4))
          $display("FAIL rand_slice%0d: got %h expected %h", n_out, act_slice(), exp_slice(w, n_out % 4));
        else n_pass++;
        if (out_ready) n_out++;
      end
      if (pres && in_ready) begin
        pres = 1'b0;
        wi++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (n_out !== 96)
      $display("FAIL rand_slice_count: got %0d expected 96", n_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single(32'h12FF_34FF, "single");
    test_single(32'hFFFF_FFFF, "allones");
    test_single($urandom, "randword");
    test_back_to_back(32'hAABB_CCDD, 32'h0000_0001);
    test_backpressure(32'h5566_7788);
    test_reset_mid_word();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
